// File: rtl/sha3_pad_packer.sv
// Packs a 32-bit AXI-Stream byte message into SHA-3 rate blocks with 0x06..0x80 padding.
// Each block is presented as a 1600-bit state-shaped word; capacity bits stay zero.
module sha3_pad_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STATE_W    = 1600
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    Mode,
  input  logic [DATA_WIDTH-1:0]   TDATA_i,
  input  logic [DATA_WIDTH/8-1:0] TKEEP_i,
  input  logic                    TVALID_i,
  input  logic                    TLAST_i,
  output logic                    TREADY,
  output logic [STATE_W-1:0]      m_block,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    protocol_err
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_PADBLK} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  pad_pend_q, pad_pend_d;
  logic                  tready_q, tready_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [STATE_W-1:0]    blk_q, blk_d;

  logic                  accept, keep_contig, mode_eff;
  logic [7:0]            cnt_new, r_bytes, r_last;
  logic [2:0]            nkeep, nbytes;
  logic [1:0]            k;
  logic [DATA_WIDTH-1:0] packed_beat, wr_beat;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;

    // The rate for the first beat must follow the live Mode input, not the stale mode_q.
    mode_eff = (state_q == S_IDLE) ? Mode : mode_q;
    r_bytes  = mode_eff ? 8'd72 : 8'd136;
    r_last   = r_bytes - 8'd1;
    accept   = TVALID_i & tready_q;

    nkeep       = 3'($countones(TKEEP_i));
    keep_contig = TKEEP_i inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

    packed_beat = '0;
    k           = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (TKEEP_i[i]) begin
        packed_beat[{k, 3'b000} +: 8] = TDATA_i[8*i +: 8];
        k = k + 2'd1;
      end
    end
    // Only the final beat may be short; any other beat counts as a full word.
    wr_beat = TLAST_i ? packed_beat : TDATA_i;
    nbytes  = TLAST_i ? nkeep : 3'(NB);
    cnt_new = cnt_q + {5'b0, nbytes};

    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (state_q == S_IDLE) mode_d = Mode;
          for (int unsigned i = 0; i < NB; i++) begin
            if (3'(i) < nbytes) blk_d[{cnt_q + 8'(i), 3'b000} +: 8] = wr_beat[8*i +: 8];
          end
          if ((!TLAST_i && TKEEP_i != 4'hF) || !keep_contig) err_d = 1'b1;
          cnt_d   = cnt_new;
          state_d = S_FILL;
          if (TLAST_i && cnt_new < r_bytes) begin
            blk_d[{cnt_new, 3'b000} +: 8] = blk_d[{cnt_new, 3'b000} +: 8] ^ 8'h06;
            blk_d[{r_last, 3'b000} +: 8]  = blk_d[{r_last, 3'b000} +: 8] ^ 8'h80;
            state_d = S_EMIT;
            valid_d = 1'b1;
            last_d  = 1'b1;
          end else if (cnt_new == r_bytes) begin
            state_d    = S_EMIT;
            valid_d    = 1'b1;
            last_d     = 1'b0;
            pad_pend_d = TLAST_i;
          end
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          blk_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (pad_pend_q)  state_d = S_PADBLK;
          else if (last_q) state_d = S_IDLE;
          else             state_d = S_FILL;
        end
      end
      S_PADBLK: begin
        blk_d                        = '0;
        blk_d[7:0]                   = 8'h06;
        blk_d[{r_last, 3'b000} +: 8] = 8'h80;
        pad_pend_d = 1'b0;
        last_d     = 1'b1;
        valid_d    = 1'b1;
        state_d    = S_EMIT;
      end
      default: state_d = S_IDLE;
    endcase

    tready_d = (state_d == S_IDLE) || (state_d == S_FILL);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      tready_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
      tready_q   <= tready_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
    end
  end

  assign TREADY       = tready_q;
  assign m_block      = blk_q;
  assign m_valid      = valid_q;
  assign m_last       = last_q;
  assign protocol_err = err_q;
endmodule
